ext_mem_host: RTL and testbench

- Host-side initiator for the cpu external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and their _2 data-memory counterparts).
- Streams a program into instruction memory and an initial image into data memory, then drives the cpu enable for a programmed cycle count.
- Finally reads data memory back out over a 64-bit output stream.
- Sits beside cpu in the top-level/testbench harness; replaces ad-hoc testbench tasks.

---
 rtl/ext_mem_host_pkg.sv | 25 ++
 rtl/ext_mem_host_dump.sv | 36 +++
 rtl/ext_mem_host.sv | 174 +++++++++++++++++
 tb/tb_ext_mem_host.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_host_pkg.sv
// rtl/ext_mem_host_pkg.sv - shared states, word sizes and length clamp for ext_mem_host
package ext_mem_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  localparam int unsigned IMEM_WORD_BYTES = 4;
  localparam int unsigned DMEM_WORD_BYTES = 8;

  // Limit a requested word count to the memory depth so the index never wraps.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input int unsigned addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/ext_mem_host_dump.sv
// rtl/ext_mem_host_dump.sv - dmem read, capture and output-stream handshake for the dump phase
module ext_mem_host_dump
  import ext_mem_host_pkg::*;
#(
  parameter int IDX_W = 11
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             rd,
  input  logic             cap,
  input  logic             out,
  input  logic [IDX_W-1:0] index,
  input  logic             m_ready,
  input  logic [63:0]      rdata,
  output logic             ren,
  output logic [63:0]      addr,
  output logic             m_valid,
  output logic [63:0]      m_data,
  output logic             word_done
);

  assign ren       = rd;
  assign addr      = 64'(index) * 64'(DMEM_WORD_BYTES);
  assign m_valid   = out;
  assign word_done = out & m_ready;

  // Read data arrives one cycle after ren; hold it until the stream takes it.
  always_ff @(posedge clk) begin
    if (srst) begin
      m_data <= '0;
    end else if (cap) begin
      m_data <= rdata;
    end
  end

endmodule

// File: rtl/ext_mem_host.sv
// rtl/ext_mem_host.sv - loads imem/dmem from a stream, runs the cpu, then streams dmem back out
module ext_mem_host
  import ext_mem_host_pkg::*;
#(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int RUN_W       = 32
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 start,
  input  logic [IMEM_ADDR_W:0] imem_len,
  input  logic [DMEM_ADDR_W:0] dmem_len,
  input  logic [RUN_W-1:0]     run_cycles,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [63:0]          s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [63:0]          m_data,
  output logic                 busy,
  output logic                 done,
  output logic                 enable,
  output logic [63:0]          addr_ext,
  output logic                 wen_ext,
  output logic                 ren_ext,
  output logic [31:0]          wdata_ext,
  input  logic [31:0]          rdata_ext,
  output logic [63:0]          addr_ext_2,
  output logic                 wen_ext_2,
  output logic                 ren_ext_2,
  output logic [63:0]          wdata_ext_2,
  input  logic [63:0]          rdata_ext_2
);

  localparam int IDX_W = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, imem_cnt, dmem_cnt;
  logic [RUN_W-1:0] run_left;
  logic             accept, last_i, last_d;
  logic             wen_q2, wr_pending, issue_rd;
  logic             dump_cap, dump_out, dump_ren, word_done;
  logic [63:0]      addr_q2, dump_addr;
  logic             unused_rdata;

  assign s_ready = (state == S_LOAD_I) || (state == S_LOAD_D);
  assign accept  = s_valid & s_ready;
  assign last_i  = (idx + IDX_W'(1)) == imem_cnt;
  assign last_d  = (idx + IDX_W'(1)) == dmem_cnt;

  // The final load write lands one cycle after its accept; hold off enable
  // and dump reads until it has drained so they never share a cycle.
  assign wr_pending = wen_ext | wen_q2;
  assign enable     = (state == S_RUN) && !wr_pending;
  assign issue_rd   = (state == S_DUMP_RD) && !wr_pending;
  assign dump_cap   = (state == S_DUMP_WAIT);
  assign dump_out   = (state == S_DUMP_OUT);

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  assign ren_ext      = 1'b0;
  assign wen_ext_2    = wen_q2;
  assign ren_ext_2    = dump_ren;
  assign addr_ext_2   = dump_ren ? dump_addr : addr_q2;
  assign unused_rdata = ^rdata_ext;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (imem_len != '0)        state_next = S_LOAD_I;
          else if (dmem_len != '0)   state_next = S_LOAD_D;
          else if (run_cycles != '0) state_next = S_RUN;
          else                       state_next = S_DONE;
        end
      end
      S_LOAD_I: begin
        if (accept && last_i) begin
          if (dmem_cnt != '0)      state_next = S_LOAD_D;
          else if (run_left != '0) state_next = S_RUN;
          else                     state_next = S_DONE;
        end
      end
      S_LOAD_D: begin
        if (accept && last_d) state_next = (run_left != '0) ? S_RUN : S_DUMP_RD;
      end
      S_RUN: begin
        if (enable && (run_left == RUN_W'(1)))
          state_next = (dmem_cnt != '0) ? S_DUMP_RD : S_DONE;
      end
      S_DUMP_RD:   if (!wr_pending) state_next = S_DUMP_WAIT;
      S_DUMP_WAIT: state_next = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (word_done) state_next = last_d ? S_DONE : S_DUMP_RD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= S_IDLE;
      idx         <= '0;
      imem_cnt    <= '0;
      dmem_cnt    <= '0;
      run_left    <= '0;
      wen_ext     <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_q2      <= 1'b0;
      addr_q2     <= '0;
      wdata_ext_2 <= '0;
    end else begin
      state   <= state_next;
      wen_ext <= 1'b0;
      wen_q2  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            imem_cnt <= IDX_W'(clamp_len(32'(imem_len), IMEM_ADDR_W));
            dmem_cnt <= IDX_W'(clamp_len(32'(dmem_len), DMEM_ADDR_W));
            run_left <= run_cycles;
            idx      <= '0;
          end
        end
        S_LOAD_I: begin
          if (accept) begin
            wen_ext   <= 1'b1;
            addr_ext  <= 64'(idx) * 64'(IMEM_WORD_BYTES);
            wdata_ext <= s_data[31:0];
            idx       <= last_i ? '0 : idx + IDX_W'(1);
          end
        end
        S_LOAD_D: begin
          if (accept) begin
            wen_q2      <= 1'b1;
            addr_q2     <= 64'(idx) * 64'(DMEM_WORD_BYTES);
            wdata_ext_2 <= s_data;
            idx         <= last_d ? '0 : idx + IDX_W'(1);
          end
        end
        S_RUN: begin
          if (enable) run_left <= run_left - RUN_W'(1);
        end
        S_DUMP_OUT: begin
          if (word_done) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  ext_mem_host_dump #(
    .IDX_W(IDX_W)
  ) u_dump (
    .clk       (clk),
    .srst      (srst),
    .rd        (issue_rd),
    .cap       (dump_cap),
    .out       (dump_out),
    .index     (idx),
    .m_ready   (m_ready),
    .rdata     (rdata_ext_2),
    .ren       (dump_ren),
    .addr      (dump_addr),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_ext_mem_host.sv
// tb/tb_ext_mem_host.sv - directed scoreboard bench for ext_mem_host
module tb_ext_mem_host;

  localparam int IMEM_ADDR_W = 9;
  localparam int DMEM_ADDR_W = 10;
  localparam int RUN_W       = 32;
  localparam int IL_W        = IMEM_ADDR_W + 1;
  localparam int DL_W        = DMEM_ADDR_W + 1;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 srst = 1'b1;
  logic                 start = 1'b0;
  logic [IL_W-1:0]      imem_len;
  logic [DL_W-1:0]      dmem_len;
  logic [RUN_W-1:0]     run_cycles;
  logic                 s_valid, s_ready, m_valid, m_ready;
  logic [63:0]          s_data, m_data;
  logic                 busy, done, enable;
  logic [63:0]          addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic                 wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]          wdata_ext, rdata_ext;

  wr_t         imem_q[$];
  wr_t         dmem_q[$];
  logic [63:0] dump_q[$];
  int          wcyc_i[$];
  int          wcyc_d[$];
  logic [63:0] words[8];
  logic [63:0] mem[1024];
  wr_t         mon_e;
  logic [63:0] mon_d;
  int          cyc = 0;
  int          en_cnt = 0;
  int          mv_cnt = 0;
  int          total = 0;
  int          bad = 0;
  int          e0, m0;

  always #5 clk = ~clk;

  ext_mem_host #(
    .IMEM_ADDR_W(IMEM_ADDR_W),
    .DMEM_ADDR_W(DMEM_ADDR_W),
    .RUN_W(RUN_W)
  ) dut (
    .clk(clk), .srst(srst), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .enable(enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  // Data memory with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wen_ext_2 === 1'b1) mem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2 === 1'b1) rdata_ext_2 <= mem[addr_ext_2[12:3]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin
      wcyc_i.push_back(cyc);
      chk("imem_exp_avail", 64'(imem_q.size() != 0), 64'd1);
      if (imem_q.size() != 0) begin
        mon_e = imem_q.pop_front();
        chk("imem_addr", addr_ext, mon_e.addr);
        chk("imem_data", 64'(wdata_ext), mon_e.data);
      end
    end
    if (wen_ext_2 === 1'b1) begin
      wcyc_d.push_back(cyc);
      chk("dmem_exp_avail", 64'(dmem_q.size() != 0), 64'd1);
      if (dmem_q.size() != 0) begin
        mon_e = dmem_q.pop_front();
        chk("dmem_addr", addr_ext_2, mon_e.addr);
        chk("dmem_data", wdata_ext_2, mon_e.data);
      end
    end
    if (enable === 1'b1) begin
      en_cnt++;
      chk("run_no_mem_access", 64'({wen_ext, wen_ext_2, ren_ext_2}), 64'd0);
    end
    if (m_valid === 1'b1) begin
      mv_cnt++;
      if (m_ready === 1'b1) begin
        chk("dump_exp_avail", 64'(dump_q.size() != 0), 64'd1);
        if (dump_q.size() != 0) begin
          mon_d = dump_q.pop_front();
          chk("dump_data", m_data, mon_d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int il, input int dl, input int rc);
    imem_len   = IL_W'(il);
    dmem_len   = DL_W'(dl);
    run_cycles = RUN_W'(rc);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int cnt, input logic [15:0] vpat);
    int   n = 0;
    int   c = 0;
    logic acc;
    while (n < cnt && c < 64) begin
      s_valid = (c < 16) ? vpat[c[3:0]] : 1'b1;
      s_data  = words[n[2:0]];
      @(negedge clk);
      acc = s_valid & s_ready;
      step();
      if (acc) n++;
      c++;
    end
    s_valid = 1'b0;
    chk("feed_count", 64'(n), 64'(cnt));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && done !== 1'b1; i++) step();
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_drained(input string tag);
    chk(tag, 64'(imem_q.size() + dmem_q.size() + dump_q.size()), 64'd0);
  endtask

  initial begin
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1; rdata_ext = '0;
    imem_len = '0; dmem_len = '0; run_cycles = '0;

    // Reset state
    repeat (2) step();
    chk("rst_ctl", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2, m_valid, busy, done, enable, s_ready}), 64'd0);
    chk("rst_data", addr_ext | addr_ext_2 | wdata_ext_2 | m_data | 64'(wdata_ext), 64'd0);
    srst = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Back-to-back load of both memories, then dump with m_ready high
    words[0] = 64'h13; words[1] = 64'h93; words[2] = 64'h113; words[3] = 64'hAA; words[4] = 64'hBB;
    wcyc_i.delete(); wcyc_d.delete();
    imem_q.push_back('{addr: 64'd0, data: 64'h13});
    imem_q.push_back('{addr: 64'd4, data: 64'h93});
    imem_q.push_back('{addr: 64'd8, data: 64'h113});
    dmem_q.push_back('{addr: 64'd0, data: 64'hAA});
    dmem_q.push_back('{addr: 64'd8, data: 64'hBB});
    dump_q.push_back(64'hAA); dump_q.push_back(64'hBB);
    launch(3, 2, 0);
    feed(5, 16'hFFFF);
    chk("load_sready_low", 64'(s_ready), 64'd0);
    wait_done("load_done");
    chk("load_imem_wr_count", 64'(wcyc_i.size()), 64'd3);
    chk("load_dmem_wr_count", 64'(wcyc_d.size()), 64'd2);
    if (wcyc_i.size() == 3 && wcyc_d.size() == 2) begin
      chk("load_imem_b2b", 64'(wcyc_i[2] - wcyc_i[0]), 64'd2);
      chk("load_dmem_follows", 64'(wcyc_d[0] - wcyc_i[2]), 64'd1);
    end
    chk_drained("load_drained");

    // Stalled stream during LOAD_D: valid pattern 1,0,0,1
    words[0] = 64'h55; words[1] = 64'h66;
    wcyc_d.delete();
    dmem_q.push_back('{addr: 64'd0, data: 64'h55});
    dmem_q.push_back('{addr: 64'd8, data: 64'h66});
    dump_q.push_back(64'h55); dump_q.push_back(64'h66);
    launch(0, 2, 0);
    feed(2, 16'hFFF9);
    wait_done("stall_done");
    chk("stall_wr_count", 64'(wcyc_d.size()), 64'd2);
    if (wcyc_d.size() == 2) chk("stall_wr_gap", 64'(wcyc_d[1] - wcyc_d[0]), 64'd3);
    chk_drained("stall_drained");

    // Run for 5 cycles; a start pulse while busy must be ignored
    e0 = en_cnt;
    launch(0, 0, 5);
    imem_len = IL_W'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("run_done");
    chk("run_en_cycles", 64'(en_cnt - e0), 64'd5);

    // Run right after a load: enable must wait for the last write
    words[0] = 64'h7;
    imem_q.push_back('{addr: 64'd0, data: 64'h7});
    e0 = en_cnt;
    launch(1, 0, 3);
    feed(1, 16'hFFFF);
    wait_done("run_load_done");
    chk("run_load_en_cycles", 64'(en_cnt - e0), 64'd3);
    chk_drained("run_load_drained");

    // Dump backpressure: first word held for 4 cycles
    words[0] = 64'h11; words[1] = 64'h22;
    dmem_q.push_back('{addr: 64'd0, data: 64'h11});
    dmem_q.push_back('{addr: 64'd8, data: 64'h22});
    dump_q.push_back(64'h11); dump_q.push_back(64'h22);
    m_ready = 1'b0;
    launch(0, 2, 0);
    feed(2, 16'hFFFF);
    for (int i = 0; i < 20 && m_valid !== 1'b1; i++) step();
    chk("bp_mvalid_seen", 64'(m_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", 64'(m_valid), 64'd1);
      chk("bp_hold_data", m_data, 64'h11);
      step();
    end
    m_ready = 1'b1;
    wait_done("bp_done");
    chk_drained("bp_drained");

    // Zero lengths straight from IDLE
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("zero_pre_done", 64'(done), 64'd0);
    e0 = en_cnt; m0 = mv_cnt;
    launch(0, 0, 0);
    chk("zero_done", 64'(done), 64'd1);
    repeat (3) step();
    chk("zero_no_enable", 64'(en_cnt - e0), 64'd0);
    chk("zero_no_mvalid", 64'(mv_cnt - m0), 64'd0);

    // Reset in the middle of LOAD_I after 3 words
    words[0] = 64'h13; words[1] = 64'h93; words[2] = 64'h113;
    imem_q.push_back('{addr: 64'd0, data: 64'h13});
    imem_q.push_back('{addr: 64'd4, data: 64'h93});
    imem_q.push_back('{addr: 64'd8, data: 64'h113});
    launch(8, 0, 0);
    feed(3, 16'hFFFF);
    s_valid = 1'b1;
    srst = 1'b1;
    step();
    chk("rst_mid_ctl", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2, m_valid, busy, done, enable, s_ready}), 64'd0);
    chk("rst_mid_data", addr_ext | addr_ext_2 | wdata_ext_2 | m_data | 64'(wdata_ext), 64'd0);
    step();
    srst = 1'b0;
    repeat (4) step();
    chk("rst_mid_idle", 64'({busy, s_ready}), 64'd0);
    s_valid = 1'b0;
    chk_drained("rst_mid_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
